// File: rtl/pipe_hazard_ctrl.sv
// Hazard and pipeline control for the in-order pipeline: in-flight writer scoreboard,
// RAW stall/forward decisions for ID, and jr flush. Forwarding enabled by `PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int LAT   = 1,
    parameter int SELW  = 2,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_rs_use,
    input  logic            id_rt_use,
    input  logic            id_wrf,
    input  logic [AW-1:0]   id_waddr,
    input  logic            id_jr,
    output logic            pc_ena,
    output logic            ifid_ena,
    output logic            ifid_flush,
    output logic            ex_bubble,
    output logic [SELW-1:0] fwd_a,
    output logic [SELW-1:0] fwd_b,
    output logic [CW-1:0]   stall_cnt
);

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [SELW-1:0] LAT_SEL = SELW'(LAT);

    // Position k holds the writer issued k edges ago; position DEPTH writes back this cycle.
    logic [DEPTH:1] sb_v;
    logic [AW-1:0]  sb_a [1:DEPTH];

    logic            match_a;
    logic            match_b;
    logic [SELW-1:0] pos_a;
    logic [SELW-1:0] pos_b;
    logic            haz_a;
    logic            haz_b;
    logic            stall;
    logic            issue;

    // Scan oldest to youngest so the youngest matching writer is the one kept.
    always_comb begin
        match_a = 1'b0;
        match_b = 1'b0;
        pos_a   = '0;
        pos_b   = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_rs_use && (id_rs != '0) && sb_v[k] && (sb_a[k] == id_rs)) begin
                match_a = 1'b1;
                pos_a   = SELW'(k);
            end
            if (id_rt_use && (id_rt != '0) && sb_v[k] && (sb_a[k] == id_rt)) begin
                match_b = 1'b1;
                pos_b   = SELW'(k);
            end
        end
    end

    // A match is harmless only when forwarding exists and the result is already available.
    assign haz_a = match_a && !(FWD_EN && (pos_a >= LAT_SEL));
    assign haz_b = match_b && !(FWD_EN && (pos_b >= LAT_SEL));
    assign stall = id_valid && (haz_a || haz_b);
    assign issue = id_valid && !stall;

    assign pc_ena     = !stall;
    assign ifid_ena   = !stall;
    assign ex_bubble  = stall;
    assign ifid_flush = issue && id_jr;

`ifdef PIPE_HAZARD_FWD_EN
    assign fwd_a = (match_a && !haz_a) ? pos_a : '0;
    assign fwd_b = (match_b && !haz_b) ? pos_b : '0;
`else
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v      <= '0;
            stall_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                sb_a[k] <= '0;
            end
        end else begin
            sb_v[1] <= issue && id_wrf && (id_waddr != '0);
            sb_a[1] <= issue ? id_waddr : '0;
            for (int k = 2; k <= DEPTH; k++) begin
                sb_v[k] <= sb_v[k-1];
                sb_a[k] <= sb_a[k-1];
            end
            if (stall && (stall_cnt != {CW{1'b1}})) begin
                stall_cnt <= stall_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; expectations follow PIPE_HAZARD_FWD_EN when defined.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_rs_use, id_rt_use, id_wrf, id_jr;
    logic [4:0] id_rs, id_rt, id_waddr;

    logic        pc_ena, ifid_ena, ifid_flush, ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    logic        pc_ena_l2, ifid_ena_l2, ifid_flush_l2, ex_bubble_l2;
    logic [1:0]  fwd_a_l2, fwd_b_l2;
    logic [15:0] stall_cnt_l2;

    logic        pc_ena_s, ifid_ena_s, ifid_flush_s, ex_bubble_s;
    logic [1:0]  fwd_a_s, fwd_b_s;
    logic [1:0]  stall_cnt_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.AW(5), .DEPTH(3), .LAT(1), .SELW(2), .CW(16)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_wrf(id_wrf), .id_waddr(id_waddr),
        .id_jr(id_jr), .pc_ena(pc_ena), .ifid_ena(ifid_ena), .ifid_flush(ifid_flush),
        .ex_bubble(ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt));

    pipe_hazard_ctrl #(.AW(5), .DEPTH(3), .LAT(2), .SELW(2), .CW(16)) u_lat2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_wrf(id_wrf), .id_waddr(id_waddr),
        .id_jr(id_jr), .pc_ena(pc_ena_l2), .ifid_ena(ifid_ena_l2), .ifid_flush(ifid_flush_l2),
        .ex_bubble(ex_bubble_l2), .fwd_a(fwd_a_l2), .fwd_b(fwd_b_l2), .stall_cnt(stall_cnt_l2));

    pipe_hazard_ctrl #(.AW(5), .DEPTH(3), .LAT(3), .SELW(2), .CW(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_wrf(id_wrf), .id_waddr(id_waddr),
        .id_jr(id_jr), .pc_ena(pc_ena_s), .ifid_ena(ifid_ena_s), .ifid_flush(ifid_flush_s),
        .ex_bubble(ex_bubble_s), .fwd_a(fwd_a_s), .fwd_b(fwd_b_s), .stall_cnt(stall_cnt_s));

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ru;
        logic       tu;
        logic       wrf;
        logic [4:0] wa;
        logic       jr;
        logic       pc;
        logic       ifid;
        logic       fl;
        logic       bub;
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;
    } vec_t;

    localparam int NVEC = 11;
    vec_t tbl [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ru, input logic tu, input logic wrf,
                         input logic [4:0] wa, input logic jr);
        id_valid  = v;
        id_rs     = rs;
        id_rt     = rt;
        id_rs_use = ru;
        id_rt_use = tu;
        id_wrf    = wrf;
        id_waddr  = wa;
        id_jr     = jr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic vec_t st(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ru, input logic tu, input logic wrf,
                                input logic [4:0] wa, input logic jr);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.ru = ru; r.tu = tu;
        r.wrf = wrf; r.wa = wa; r.jr = jr;
        r.pc = 1'b1; r.ifid = 1'b1; r.fl = 1'b0; r.bub = 1'b0;
        r.fa = 2'd0; r.fb = 2'd0; r.cnt = 0;
        return r;
    endfunction

    task automatic ex(input int i, input logic stl, input logic [1:0] fa,
                      input logic [1:0] fb, input int cnt);
        tbl[i].pc   = !stl;
        tbl[i].ifid = !stl;
        tbl[i].bub  = stl;
        tbl[i].fl   = 1'b0;
        tbl[i].fa   = fa;
        tbl[i].fb   = fb;
        tbl[i].cnt  = cnt;
    endtask

    function automatic logic pc_of(input int which);
        if (which == 1) return pc_ena_l2;
        if (which == 2) return pc_ena_s;
        return pc_ena;
    endfunction

    // Called at a sample point with the instruction already driven; returns at the issue cycle.
    task automatic count_stalls(input int which, output int n, output int flush_bad);
        n = 0;
        flush_bad = 0;
        while (pc_of(which) == 1'b0 && n < 20) begin
            if (ifid_flush) flush_bad++;
            n++;
            @(negedge clk);
            #2;
        end
        if (n >= 20) begin
            failures++;
            $display("FAIL stall_bound instance=%0d actual=%0d required=<20", which, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, fb_bad;

        tbl[0]  = st(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
        tbl[1]  = st(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        tbl[2]  = st(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        tbl[3]  = st(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        tbl[4]  = st(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        tbl[5]  = st(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0);
        tbl[6]  = st(1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 0);
        tbl[7]  = st(1, 5'd9, 5'd4, 0, 1, 1, 5'd6, 0);
        tbl[8]  = st(1, 5'd9, 5'd4, 0, 1, 1, 5'd6, 0);
        tbl[9]  = st(0, 5'd6, 5'd0, 1, 0, 0, 5'd0, 0);
        tbl[10] = st(1, 5'd6, 5'd0, 0, 0, 0, 5'd0, 0);
`ifdef PIPE_HAZARD_FWD_EN
        ex(0, 0, 0, 0, 0);  ex(1, 0, 1, 1, 0);  ex(2, 0, 2, 2, 0);  ex(3, 0, 3, 3, 0);
        ex(4, 0, 0, 0, 0);  ex(5, 0, 0, 0, 0);  ex(6, 0, 0, 0, 0);  ex(7, 0, 0, 3, 0);
        ex(8, 0, 0, 0, 0);  ex(9, 0, 1, 0, 0);  ex(10, 0, 0, 0, 0);
`else
        ex(0, 0, 0, 0, 0);  ex(1, 1, 0, 0, 0);  ex(2, 1, 0, 0, 1);  ex(3, 1, 0, 0, 2);
        ex(4, 0, 0, 0, 3);  ex(5, 0, 0, 0, 3);  ex(6, 0, 0, 0, 3);  ex(7, 1, 0, 0, 3);
        ex(8, 0, 0, 0, 4);  ex(9, 0, 0, 0, 4);  ex(10, 0, 0, 0, 4);
`endif

        // Reset state with an idle ID stage
        do_reset();
        #2;
        chk("rst_pc_ena", pc_ena, 1);
        chk("rst_ifid_ena", ifid_ena, 1);
        chk("rst_ifid_flush", ifid_flush, 0);
        chk("rst_ex_bubble", ex_bubble, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);

        // Vector table
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].ru, tbl[i].tu,
                  tbl[i].wrf, tbl[i].wa, tbl[i].jr);
            #2;
            chk($sformatf("vec%0d_pc_ena", i), pc_ena, tbl[i].pc);
            chk($sformatf("vec%0d_ifid_ena", i), ifid_ena, tbl[i].ifid);
            chk($sformatf("vec%0d_ifid_flush", i), ifid_flush, tbl[i].fl);
            chk($sformatf("vec%0d_ex_bubble", i), ex_bubble, tbl[i].bub);
            chk($sformatf("vec%0d_fwd_a", i), fwd_a, tbl[i].fa);
            chk($sformatf("vec%0d_fwd_b", i), fwd_b, tbl[i].fb);
            chk($sformatf("vec%0d_stall_cnt", i), stall_cnt, tbl[i].cnt);
            @(negedge clk);
        end

        // Two writers of $5 two cycles apart: the younger one is selected
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0); @(negedge clk);
        drive(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0); @(negedge clk);
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd5, 0); @(negedge clk);
        drive(1, 5'd5, 5'd0, 1, 0, 0, 5'd0, 0);
        #2;
        chk("youngest_fwd_a", fwd_a, FWD ? 1 : 0);
        count_stalls(0, n, fb_bad);
        chk("youngest_stalls", n, FWD ? 0 : 3);
        chk("youngest_issue_fwd_a", fwd_a, FWD ? 1 : 0);
        @(negedge clk);

        // jr on a register still in flight
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd7, 0); @(negedge clk);
        drive(1, 5'd7, 5'd0, 1, 0, 0, 5'd0, 1);
        #2;
        count_stalls(0, n, fb_bad);
        chk("jr_stalls", n, FWD ? 0 : 3);
        chk("jr_no_flush_while_stalled", fb_bad, 0);
        chk("jr_flush", ifid_flush, 1);
        chk("jr_pc_ena", pc_ena, 1);
        chk("jr_fwd_a", fwd_a, FWD ? 1 : 0);
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
        #2;
        chk("jr_flush_drops", ifid_flush, 0);
        @(negedge clk);

        // Dependent instruction directly behind a writer on the LAT=2 instance
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0); @(negedge clk);
        drive(1, 5'd3, 5'd3, 1, 1, 1, 5'd4, 0);
        #2;
        count_stalls(1, n, fb_bad);
        chk("lat2_stalls", n, FWD ? 1 : 3);
        chk("lat2_fwd_a", fwd_a_l2, FWD ? 2 : 0);
        chk("lat2_fwd_b", fwd_b_l2, FWD ? 2 : 0);
        chk("lat2_stall_cnt", stall_cnt_l2, FWD ? 1 : 3);
        chk("lat1_stall_cnt", stall_cnt, FWD ? 0 : 3);
        @(negedge clk);

        // Reset pulse while the LAT=2 instance is stalling
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd8, 0); @(negedge clk);
        drive(1, 5'd8, 5'd0, 1, 0, 0, 5'd0, 0);
        #2;
        chk("midrst_stalling", pc_ena_l2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("midrst_pc_ena", pc_ena_l2, 1);
        chk("midrst_ex_bubble", ex_bubble_l2, 0);
        chk("midrst_fwd_a", fwd_a_l2, 0);
        chk("midrst_stall_cnt", stall_cnt_l2, 0);
        chk("midrst_main_fwd_a", fwd_a, 0);
        @(negedge clk);

        // Saturation of a 2-bit stall counter over two back-to-back dependencies
        do_reset();
        drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd10, 0); @(negedge clk);
        drive(1, 5'd10, 5'd0, 1, 0, 1, 5'd10, 0);
        #2;
        count_stalls(2, n, fb_bad);
        @(negedge clk);
        #2;
        count_stalls(2, n2, fb_bad);
        chk("sat_total_stalls", n + n2, FWD ? 4 : 6);
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
        #2;
        chk("sat_stall_cnt", stall_cnt_s, 3);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and pipeline control unit for the in-order R-type CPU pipeline (IF, ID, then DEPTH in-flight stages ending in register writeback). It replaces the tied-off `pc_ena = 1` and the flat rd1/rd2 paths with three things: a scoreboard of in-flight destination registers, read-after-write stall/forward decisions for the instruction in ID, and a jr flush for the IF/ID register. It sits beside the ID stage and drives the PC register, the IF/ID register, the ID/EXE bubble mux and the EXE operand muxes.

## Interface
Parameters:
- AW, 5, register address width
- DEPTH, 3, in-flight stages after ID; position DEPTH writes the register file at the end of its cycle
- LAT, 1, first position (1..DEPTH) at which a result can be forwarded
- SELW, 2, forward-select width; 2^SELW > DEPTH
- CW, 16, stall counter width

Ports:
- clk  in  1  clock; everything updates on the rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs, id_rt  in  AW  source registers
- id_rs_use, id_rt_use  in  1  source is actually read
- id_wrf  in  1  instruction writes a register
- id_waddr  in  AW  destination register
- id_jr  in  1  instruction is jr; target is rs
- pc_ena  out  1  PC register enable
- ifid_ena  out  1  IF/ID register enable
- ifid_flush  out  1  load a NOP into IF/ID
- ex_bubble  out  1  inject a NOP into ID/EXE
- fwd_a, fwd_b  out  SELW  operand source: 0 = register file, k = result at position k
- stall_cnt  out  CW  saturating count of stall cycles

## Operation
- Scoreboard: sb_v[1..DEPTH], sb_a[1..DEPTH].
  - Each edge, entry k moves to k+1.
  - Entry DEPTH retires.
  - Entry 1 loads {id_wrf && id_waddr != 0, id_waddr} when issue = id_valid && !stall; otherwise it loads {0, 0}.
- Match for source s: applies when use=1 and s != 0. Take the smallest k with sb_v[k] && sb_a[k] == s (the youngest writer wins).
- With forwarding:
  - Source hazard when the matching k < LAT.
  - Otherwise fwd = k, or 0 if there is no match.
- Without forwarding:
  - Any match is a hazard.
  - fwd_a and fwd_b are always 0.
- stall = id_valid && (rs hazard || rt hazard).
- Outputs when stalled: pc_ena = 0, ifid_ena = 0, ex_bubble = 1, ifid_flush = 0.
- jr: when id_valid && id_jr && !stall, ifid_flush = 1 and pc_ena = 1, which squashes the sequentially fetched instruction. A jr whose rs is in hazard stalls and does not flush until it issues.
- Outputs with no stall: pc_ena = 1, ifid_ena = 1, ex_bubble = 0.
- stall_cnt increments on every stall cycle and saturates at 2^CW − 1.
- Reset:
  - Clears sb_v, sb_a and stall_cnt on the edge where rst = 1; rst overrides issue.
  - After reset with id_valid = 0: pc_ena = 1, ifid_ena = 1, ifid_flush = 0, ex_bubble = 0, fwd = 0.
  - A reset mid-operation drops all in-flight entries, so no hazards remain.

## Timing
- Control outputs are combinational from the ID inputs and the current scoreboard, valid in the same cycle.
- The scoreboard and stall_cnt have one edge of latency.
- A writer issued at edge t is at position k during cycle t+k, for k = 1..DEPTH. It is absent from cycle t+DEPTH+1, when the register file already holds its value.
- Dependent instruction directly behind a writer, with forwarding: LAT − 1 stall cycles, then fwd = LAT.
- Same case without forwarding: DEPTH stall cycles, then fwd = 0.
- A stall holds the ID inputs stable; the bench must keep them constant.
- Register $0 never creates a hazard or a forward.

## Configuration
- PIPE_HAZARD_FWD_EN defined: forwarding active as described; fwd_a/fwd_b are driven and the LAT rule applies.
- PIPE_HAZARD_FWD_EN undefined: no forwarding logic; fwd_a/fwd_b are tied to 0; every match stalls until the writer retires.

## Test plan
All scenarios use DEPTH = 3.
- FWD_EN, LAT = 1: issue add $3,$1,$2; next cycle add $4,$3,$3 → no stall, fwd_a = 1, fwd_b = 1, stall_cnt = 0.
- No FWD_EN, same sequence → 3 stall cycles (pc_ena = 0, ex_bubble = 1), issues in the 4th cycle with fwd = 0, stall_cnt = 3.
- FWD_EN, LAT = 2, same sequence → 1 stall cycle, then fwd_a = 2.
- Writers to $5 issued two cycles apart, consumer of $5 immediately after the second (FWD_EN, LAT = 1) → fwd_a = 1, not 2. A writer to $0 followed by a reader of $0 → fwd = 0, no stall.
- Writer to $7 then jr $7, with no FWD_EN → 3 stall cycles with ifid_flush = 0, then one cycle with ifid_flush = 1 and pc_ena = 1.
- rst pulsed for one cycle while a hazard is stalling ID → next cycle no stall, fwd = 0, stall_cnt = 0. With CW = 2 and more than 3 stall cycles → stall_cnt holds at 3.
